// File: rtl/descriptor_header_rebuild_pkg.sv
// Shared types and constants for the egress descriptor header rebuild block.
package descriptor_header_rebuild_pkg;

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    REMAP_S = 2'd1,
    TRAN_S  = 2'd2,
    DISC_S  = 2'd3
  } rebuild_state_e;

  localparam logic [15:0] MAPPED_ETH_TYPE_DEF = 16'h1800;
  localparam logic [15:0] ETH_TYPE_TSMP       = 16'hff01;
  localparam logic [15:0] ETH_TYPE_PTP        = 16'h88f7;
  localparam logic [15:0] ETH_TYPE_PCF        = 16'h891d;

  localparam logic [2:0] PKT_TYPE_RC = 3'd3;
  localparam logic [2:0] PKT_TYPE_BE = 3'd6;

  typedef struct packed {
    logic [39:0] desc;
    logic        remap;
  } slot_entry_t;

  // Header byte k lives at desc[39-8k -: 8]; shifting left keeps the slice constant.
  function automatic logic [7:0] desc_byte(input logic [39:0] d, input logic [2:0] k);
    logic [39:0] s;
    s = d << (6'd8 * {3'd0, k});
    return s[39:32];
  endfunction

endpackage

// File: rtl/descriptor_header_rebuild_slot.sv
// One-entry descriptor holding register with same-cycle bypass when empty.
module desc_slot_reg
  import descriptor_header_rebuild_pkg::*;
#(
  parameter logic [15:0] MAPPED_ETH_TYPE = MAPPED_ETH_TYPE_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr,
  input  logic [39:0] iv_desc,
  input  logic [15:0] iv_eth,
  input  logic        i_consume,
  output logic        o_ready,
  output logic        o_avail,
  output slot_entry_t o_entry,
  output logic        o_ovf
);

  logic        slot_valid_q, slot_valid_d;
  slot_entry_t entry_q, entry_d;
  slot_entry_t wr_entry;

  assign wr_entry = '{desc: iv_desc, remap: (iv_eth == MAPPED_ETH_TYPE)};
  assign o_ready  = !slot_valid_q;
  assign o_avail  = slot_valid_q || i_wr;
  assign o_entry  = slot_valid_q ? entry_q : wr_entry;
  assign o_ovf    = i_wr && slot_valid_q;

  always_comb begin
    slot_valid_d = slot_valid_q;
    entry_d      = entry_q;
    if (i_consume && slot_valid_q) slot_valid_d = 1'b0;
    // A write into an empty slot that is consumed the same cycle is a bypass.
    if (i_wr && !slot_valid_q && !i_consume) begin
      slot_valid_d = 1'b1;
      entry_d      = wr_entry;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_valid_q <= 1'b0;
      entry_q      <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      entry_q      <= entry_d;
    end
  end

endmodule

// File: rtl/descriptor_header_rebuild.sv
// Rewrites the leading header bytes of mapped frames from their descriptor.
// REBUILD_STAT_EN enables the packet/error counters (tied to zero otherwise).
module descriptor_header_rebuild
  import descriptor_header_rebuild_pkg::*;
#(
  parameter logic [15:0] MAPPED_ETH_TYPE = MAPPED_ETH_TYPE_DEF,
  parameter int unsigned REMAP_LEN       = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_descriptor_wr,
  input  logic [39:0] iv_descriptor,
  input  logic [15:0] iv_eth_type,
  output logic        o_descriptor_ready,
  input  logic [8:0]  iv_data,
  input  logic        i_data_wr,
  output logic [8:0]  ov_data,
  output logic        o_data_wr,
  output logic [31:0] ov_pkt_cnt,
  output logic [31:0] ov_err_cnt,
  output logic [1:0]  ov_rebuild_state
);

  localparam logic [2:0] LAST_REMAP = 3'(REMAP_LEN - 1);

  rebuild_state_e state_q, state_d;
  logic [2:0]     byte_cnt_q, byte_cnt_d;
  logic [39:0]    cur_desc_q, cur_desc_d;
  logic [8:0]     data_q, data_d;
  logic           data_wr_q, data_wr_d;

  logic        consume, slot_avail, slot_ovf;
  slot_entry_t slot_entry;
  logic        pkt_inc, err_fsm, head;

  desc_slot_reg #(.MAPPED_ETH_TYPE(MAPPED_ETH_TYPE)) u_slot (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr      (i_descriptor_wr),
    .iv_desc   (iv_descriptor),
    .iv_eth    (iv_eth_type),
    .i_consume (consume),
    .o_ready   (o_descriptor_ready),
    .o_avail   (slot_avail),
    .o_entry   (slot_entry),
    .o_ovf     (slot_ovf)
  );

  assign head = i_data_wr && iv_data[8];

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    cur_desc_d = cur_desc_q;
    data_d     = data_q;
    data_wr_d  = 1'b0;
    consume    = 1'b0;
    pkt_inc    = 1'b0;
    err_fsm    = 1'b0;
    case (state_q)
      IDLE_S: begin
        if (head) begin
          if (slot_avail) begin
            consume    = 1'b1;
            cur_desc_d = slot_entry.desc;
            data_wr_d  = 1'b1;
            data_d     = {1'b1, slot_entry.remap ? desc_byte(slot_entry.desc, 3'd0) : iv_data[7:0]};
            byte_cnt_d = 3'd1;
            state_d    = (slot_entry.remap && REMAP_LEN > 1) ? REMAP_S : TRAN_S;
          end else begin
            err_fsm = 1'b1;
            state_d = DISC_S;
          end
        end
      end
      REMAP_S: begin
        if (!i_data_wr) begin
          err_fsm = 1'b1;
          state_d = IDLE_S;
        end else if (iv_data[8]) begin
          // Frame ended before the header was fully rebuilt: pass it, flag it.
          data_wr_d = 1'b1;
          data_d    = iv_data;
          err_fsm   = 1'b1;
          state_d   = IDLE_S;
        end else begin
          data_wr_d = 1'b1;
          data_d    = {1'b0, desc_byte(cur_desc_q, byte_cnt_q)};
          if (byte_cnt_q == LAST_REMAP) state_d = TRAN_S;
          else                          byte_cnt_d = byte_cnt_q + 3'd1;
        end
      end
      TRAN_S: begin
        if (!i_data_wr) begin
          err_fsm = 1'b1;
          state_d = IDLE_S;
        end else begin
          data_wr_d = 1'b1;
          data_d    = iv_data;
          if (iv_data[8]) begin
            pkt_inc = 1'b1;
            state_d = IDLE_S;
          end
        end
      end
      DISC_S: begin
        if (head) state_d = IDLE_S;
      end
      default: state_d = IDLE_S;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE_S;
      byte_cnt_q <= '0;
      cur_desc_q <= '0;
      data_q     <= '0;
      data_wr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      cur_desc_q <= cur_desc_d;
      data_q     <= data_d;
      data_wr_q  <= data_wr_d;
    end
  end

  assign ov_data          = data_q;
  assign o_data_wr        = data_wr_q;
  assign ov_rebuild_state = state_q;

`ifdef REBUILD_STAT_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;
  logic [1:0]  err_inc;

  // FSM error and descriptor overflow may land in the same cycle.
  always_comb begin
    err_inc   = {1'b0, err_fsm} + {1'b0, slot_ovf};
    pkt_cnt_d = pkt_cnt_q + {31'd0, pkt_inc};
    err_cnt_d = err_cnt_q + {30'd0, err_inc};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ov_pkt_cnt = pkt_cnt_q;
  assign ov_err_cnt = err_cnt_q;
`else
  logic unused_stat;
  assign unused_stat = ^{pkt_inc, err_fsm, slot_ovf};
  assign ov_pkt_cnt  = 32'h0;
  assign ov_err_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_descriptor_header_rebuild.sv
// Bench for descriptor_header_rebuild: vector table, directed corner sequences, random traffic.
module tb_descriptor_header_rebuild;

  localparam int          RL  = 5;
  localparam logic [15:0] MAP = 16'h1800;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_descriptor_wr;
  logic [39:0] iv_descriptor;
  logic [15:0] iv_eth_type;
  logic        o_descriptor_ready;
  logic [8:0]  iv_data;
  logic        i_data_wr;
  logic [8:0]  ov_data;
  logic        o_data_wr;
  logic [31:0] ov_pkt_cnt;
  logic [31:0] ov_err_cnt;
  logic [1:0]  ov_rebuild_state;

  descriptor_header_rebuild dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_descriptor_wr    (i_descriptor_wr),
    .iv_descriptor      (iv_descriptor),
    .iv_eth_type        (iv_eth_type),
    .o_descriptor_ready (o_descriptor_ready),
    .iv_data            (iv_data),
    .i_data_wr          (i_data_wr),
    .ov_data            (ov_data),
    .o_data_wr          (o_data_wr),
    .ov_pkt_cnt         (ov_pkt_cnt),
    .ov_err_cnt         (ov_err_cnt),
    .ov_rebuild_state   (ov_rebuild_state)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame position based, descriptor slot as a queue.
  bit          m_active, m_disc, m_remap;
  int          m_pos;
  logic [39:0] m_desc;
  logic [39:0] sq_desc[$];
  bit          sq_remap[$];
  bit   [31:0] m_pkt, m_err;
  bit          e_wr;
  logic [8:0]  e_data;

  function automatic bit [31:0] cnt(input bit [31:0] v);
`ifdef REBUILD_STAT_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  function automatic logic [7:0] dbyte(input logic [39:0] d, input int k);
    return d[39-8*k -: 8];
  endfunction

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_disc = 0; m_remap = 0; m_pos = 0; m_desc = '0;
    sq_desc.delete(); sq_remap.delete();
    m_pkt = 0; m_err = 0; e_wr = 0; e_data = '0;
  endtask

  task automatic model_step(input bit dwr, input logic [39:0] desc, input logic [15:0] eth,
                            input bit wr, input logic [8:0] data);
    bit ready0, have, bypassed, inremap;
    ready0   = (sq_desc.size() == 0);
    have     = !ready0 || dwr;
    bypassed = 0;
    e_wr     = 0;
    if (!m_active && !m_disc) begin
      if (wr && data[8]) begin
        if (have) begin
          if (!ready0) begin
            m_desc  = sq_desc.pop_front();
            m_remap = sq_remap.pop_front();
          end else begin
            m_desc   = desc;
            m_remap  = (eth == MAP);
            bypassed = 1;
          end
          m_active = 1;
          m_pos    = 1;
          e_wr     = 1;
          e_data   = {1'b1, m_remap ? dbyte(m_desc, 0) : data[7:0]};
        end else begin
          m_err++;
          m_disc = 1;
        end
      end
    end else if (m_disc) begin
      if (wr && data[8]) m_disc = 0;
    end else begin
      inremap = m_remap && (m_pos < RL);
      if (!wr) begin
        m_err++;
        m_active = 0;
      end else if (data[8]) begin
        e_wr   = 1;
        e_data = data;
        if (inremap) m_err++;
        else         m_pkt++;
        m_active = 0;
      end else begin
        e_wr   = 1;
        e_data = inremap ? {1'b0, dbyte(m_desc, m_pos)} : data;
        m_pos++;
      end
    end
    if (dwr) begin
      if (ready0) begin
        if (!bypassed) begin
          sq_desc.push_back(desc);
          sq_remap.push_back(eth == MAP);
        end
      end else begin
        m_err++;
      end
    end
  endtask

  task automatic cyc(input bit dwr, input logic [39:0] desc, input logic [15:0] eth,
                     input bit wr, input logic [8:0] data);
    @(negedge i_clk);
    i_descriptor_wr = dwr;
    iv_descriptor   = desc;
    iv_eth_type     = eth;
    i_data_wr       = wr;
    iv_data         = data;
    model_step(dwr, desc, eth, wr, data);
    @(posedge i_clk);
    #1;
    chk("data_wr", o_data_wr, e_wr);
    if (e_wr) chk("data", ov_data, e_data);
    chk("ready", o_descriptor_ready, sq_desc.size() == 0);
    chk("pkt_cnt", ov_pkt_cnt, cnt(m_pkt));
    chk("err_cnt", ov_err_cnt, cnt(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, '0);
  endtask

  typedef struct {
    bit          dwr;
    logic [39:0] desc;
    logic [15:0] eth;
    bit          wr;
    logic [8:0]  data;
    bit          ewr;
    logic [8:0]  edata;
    bit          erdy;
  } vec_t;

  vec_t vt[$];

  localparam logic [39:0] D1 = 40'hC1_2345_6789;

  initial begin
    i_rst_n = 0; i_descriptor_wr = 0; iv_descriptor = '0; iv_eth_type = '0;
    i_data_wr = 0; iv_data = '0;
    model_reset();

    // mapped rewrite then pass-through; rows are {inputs, registered outputs after the edge}
    vt.push_back('{1'b1, D1, 16'h1800, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0});
    vt.push_back('{1'b0, 40'h0, 16'h0, 1'b1, 9'h1AA, 1'b1, 9'h1C1, 1'b1});
    vt.push_back('{1'b0, 40'h0, 16'h0, 1'b1, 9'h0AA, 1'b1, 9'h023, 1'b1});
    vt.push_back('{1'b0, 40'h0, 16'h0, 1'b1, 9'h0AA, 1'b1, 9'h045, 1'b1});
    vt.push_back('{1'b0, 40'h0, 16'h0, 1'b1, 9'h0AA, 1'b1, 9'h067, 1'b1});
    vt.push_back('{1'b0, 40'h0, 16'h0, 1'b1, 9'h0AA, 1'b1, 9'h089, 1'b1});
    vt.push_back('{1'b0, 40'h0, 16'h0, 1'b1, 9'h0AA, 1'b1, 9'h0AA, 1'b1});
    vt.push_back('{1'b0, 40'h0, 16'h0, 1'b1, 9'h1AA, 1'b1, 9'h1AA, 1'b1});
    vt.push_back('{1'b0, 40'h0, 16'h0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1});
    vt.push_back('{1'b1, D1, 16'h0800, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0});
    vt.push_back('{1'b0, 40'h0, 16'h0, 1'b1, 9'h1AA, 1'b1, 9'h1AA, 1'b1});
    vt.push_back('{1'b0, 40'h0, 16'h0, 1'b1, 9'h055, 1'b1, 9'h055, 1'b1});
    vt.push_back('{1'b0, 40'h0, 16'h0, 1'b1, 9'h066, 1'b1, 9'h066, 1'b1});
    vt.push_back('{1'b0, 40'h0, 16'h0, 1'b1, 9'h1AA, 1'b1, 9'h1AA, 1'b1});

    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_data_wr", o_data_wr, 1'b0);
    chk("rst_data", ov_data, 9'h0);
    chk("rst_ready", o_descriptor_ready, 1'b1);
    chk("rst_state", ov_rebuild_state, 2'd0);
    chk("rst_pkt", ov_pkt_cnt, 32'h0);
    chk("rst_err", ov_err_cnt, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1;

    for (int i = 0; i < vt.size(); i++) begin
      cyc(vt[i].dwr, vt[i].desc, vt[i].eth, vt[i].wr, vt[i].data);
      chk("vec_wr", o_data_wr, vt[i].ewr);
      if (vt[i].ewr) chk("vec_data", ov_data, vt[i].edata);
      chk("vec_ready", o_descriptor_ready, vt[i].erdy);
    end
    idle(1);
    chk("vec_pkt", ov_pkt_cnt, cnt(2));
    chk("vec_err", ov_err_cnt, cnt(0));

    // missing descriptor: whole frame suppressed, next frame forwarded
    cyc(0, '0, '0, 1, 9'h111);
    chk("miss_head_wr", o_data_wr, 1'b0);
    cyc(0, '0, '0, 1, 9'h022);
    cyc(0, '0, '0, 1, 9'h133);
    chk("miss_tail_wr", o_data_wr, 1'b0);
    chk("miss_err", ov_err_cnt, cnt(1));
    cyc(1, 40'h0, 16'h0800, 0, '0);
    cyc(0, '0, '0, 1, 9'h144);
    cyc(0, '0, '0, 1, 9'h055);
    cyc(0, '0, '0, 1, 9'h166);
    chk("miss_next_pkt", ov_pkt_cnt, cnt(3));

    // bypass on head, refill, then overflow write
    cyc(1, 40'hAB_CDEF_0123, 16'h1800, 1, 9'h100);
    chk("byp_head", ov_data, 9'h1AB);
    cyc(1, 40'h11_2233_4455, 16'h1800, 1, 9'h000);
    chk("byp_b1", ov_data, 9'h0CD);
    cyc(1, 40'h99_9999_9999, 16'h1800, 1, 9'h000);
    chk("ovf_err", ov_err_cnt, cnt(2));
    cyc(0, '0, '0, 1, 9'h000);
    cyc(0, '0, '0, 1, 9'h000);
    chk("byp_b4", ov_data, 9'h023);
    cyc(0, '0, '0, 1, 9'h100);
    chk("byp_pkt", ov_pkt_cnt, cnt(4));

    // truncation inside the rewritten header
    cyc(0, '0, '0, 1, 9'h15A);
    chk("trunc_b0", ov_data, 9'h111);
    cyc(0, '0, '0, 1, 9'h05A);
    cyc(0, '0, '0, 1, 9'h05A);
    chk("trunc_b2", ov_data, 9'h033);
    cyc(0, '0, '0, 1, 9'h15A);
    chk("trunc_tail", ov_data, 9'h15A);
    chk("trunc_err", ov_err_cnt, cnt(3));
    chk("trunc_pkt", ov_pkt_cnt, cnt(4));

    // data gap while forwarding
    cyc(1, 40'h0, 16'h0800, 0, '0);
    cyc(0, '0, '0, 1, 9'h110);
    cyc(0, '0, '0, 1, 9'h020);
    cyc(0, '0, '0, 1, 9'h030);
    cyc(0, '0, '0, 0, 9'h000);
    chk("gap_err", ov_err_cnt, cnt(4));
    chk("gap_state", ov_rebuild_state, 2'd0);
    cyc(0, '0, '0, 1, 9'h040);
    chk("gap_drop", o_data_wr, 1'b0);

    // reset mid-frame with a pending descriptor
    cyc(1, 40'h0, 16'h0800, 0, '0);
    cyc(0, '0, '0, 1, 9'h101);
    cyc(1, 40'h55_6677_8899, 16'h1800, 1, 9'h002);
    chk("pre_rst_ready", o_descriptor_ready, 1'b0);
    i_rst_n = 0; i_data_wr = 0; i_descriptor_wr = 0;
    model_reset();
    #1;
    chk("mid_rst_wr", o_data_wr, 1'b0);
    chk("mid_rst_data", ov_data, 9'h0);
    chk("mid_rst_ready", o_descriptor_ready, 1'b1);
    chk("mid_rst_state", ov_rebuild_state, 2'd0);
    chk("mid_rst_pkt", ov_pkt_cnt, 32'h0);
    chk("mid_rst_err", ov_err_cnt, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1;
    cyc(0, '0, '0, 1, 9'h003);
    cyc(0, '0, '0, 1, 9'h004);
    chk("post_rst_drop", o_data_wr, 1'b0);
    cyc(1, 40'h55_6677_8899, 16'h1800, 0, '0);
    for (int i = 0; i < 7; i++) cyc(0, '0, '0, 1, (i == 0 || i == 6) ? 9'h1EE : 9'h0EE);
    chk("post_rst_pkt", ov_pkt_cnt, cnt(1));

    // random traffic against the model
    for (int f = 0; f < 200; f++) begin
      int len;
      if ($urandom_range(0, 9) < 8)
        cyc(1, {$urandom, 8'($urandom)}, ($urandom_range(0, 1) == 1) ? MAP : 16'($urandom), 0, '0);
      len = $urandom_range(2, 10);
      for (int b = 0; b < len; b++) begin
        bit dw;
        if ($urandom_range(0, 19) == 0) cyc(0, '0, '0, 0, '0);
        dw = ($urandom_range(0, 9) == 0);
        cyc(dw, {$urandom, 8'($urandom)}, ($urandom_range(0, 1) == 1) ? MAP : 16'h0800, 1,
            {(b == 0 || b == len - 1), 8'($urandom)});
      end
      idle($urandom_range(0, 2));
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
